expr_sig_compactor: RTL and testbench

Downstream consumer of a vloghammer expression block. Each cycle it accepts one packed 90-bit result vector `y` through a valid/ready handshake. It folds the vector into a 32-bit MISR signature over a programmed number of vectors, then compares the final signature with an expected golden value. This lets regression compare a synthesized expression netlist against reference simulation with one 32-bit check instead of a per-vector dump.

---
 rtl/expr_sig_compactor_if.sv | 18 +
 rtl/expr_sig_compactor.sv | 121 ++++++++++++
 tb/tb_expr_sig_compactor.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/expr_sig_compactor_if.sv
// Upstream result-vector stream into expr_sig_compactor.
// EXPR_SIG_PARITY_EN adds an even-parity bit alongside in_y.
interface expr_sig_compactor_if #(
  parameter int Y_WIDTH = 90
);
  logic               in_valid;
  logic               in_ready;
  logic [Y_WIDTH-1:0] in_y;
`ifdef EXPR_SIG_PARITY_EN
  logic               in_par;

  modport master (output in_valid, output in_y, output in_par, input in_ready);
  modport slave  (input in_valid, input in_y, input in_par, output in_ready);
`else
  modport master (output in_valid, output in_y, input in_ready);
  modport slave  (input in_valid, input in_y, output in_ready);
`endif
endinterface

// File: rtl/expr_sig_compactor.sv
// Folds a stream of expression result vectors into a 32-bit MISR signature
// and compares it with a golden value. Define EXPR_SIG_PARITY_EN for parity checking.
module expr_sig_compactor #(
  parameter int               Y_WIDTH   = 90,
  parameter int               SIG_WIDTH = 32,
  parameter int               CNT_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED  = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_vectors,
  expr_sig_compactor_if.slave  up,
  input  logic [SIG_WIDTH-1:0] expected_sig,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature,
`ifdef EXPR_SIG_PARITY_EN
  output logic                 par_err,
`endif
  output logic [CNT_WIDTH-1:0] vec_count
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // RUN    | accepting vectors until vec_count reaches target
  // DONE   | result held; start begins a new run
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int N_SLICES  = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PAD_WIDTH = N_SLICES * SIG_WIDTH;

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] target;
  logic [PAD_WIDTH-1:0] y_pad;
  logic [SIG_WIDTH-1:0] folded;
  logic [SIG_WIDTH-1:0] sig_next;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 accept;
  logic                 start_ok;
  logic                 par_hit;
  logic                 par_err_r;

  assign up.in_ready = (state == S_RUN);
  assign accept      = up.in_valid && up.in_ready;
  assign start_ok    = start && (state != S_RUN);
  assign busy        = (state == S_RUN);
  assign done        = (state == S_DONE);
  assign cnt_inc     = vec_count + 1'b1;

`ifdef EXPR_SIG_PARITY_EN
  assign par_hit = accept && ((^up.in_y) != up.in_par);
  assign par_err = par_err_r;
`else
  assign par_hit = 1'b0;
`endif

  assign y_pad = PAD_WIDTH'(up.in_y);

  always_comb begin
    folded = '0;
    for (int i = 0; i < N_SLICES; i++) begin
      folded = folded ^ y_pad[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  assign sig_next = {signature[SIG_WIDTH-2:0], 1'b0}
                  ^ (signature[SIG_WIDTH-1] ? POLY : '0)
                  ^ folded;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      target    <= '0;
      signature <= SEED;
      vec_count <= '0;
      pass      <= 1'b0;
      par_err_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            signature <= SEED;
            vec_count <= '0;
            par_err_r <= 1'b0;
            target    <= num_vectors;
            // Zero-length run finishes immediately, judged on the seed alone.
            if (num_vectors == '0) begin
              state <= S_DONE;
              pass  <= (SEED == expected_sig);
            end else begin
              state <= S_RUN;
              pass  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            signature <= sig_next;
            vec_count <= cnt_inc;
            if (par_hit) begin
              par_err_r <= 1'b1;
            end
            if (cnt_inc == target) begin
              state <= S_DONE;
              pass  <= (sig_next == expected_sig) && !(par_err_r || par_hit);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_sig_compactor.sv
// Randomized self-checking bench for expr_sig_compactor against a queue-based
// signature model. Parity scenario is included when EXPR_SIG_PARITY_EN is defined.
module tb_expr_sig_compactor;

  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_vectors = '0;
  logic [31:0] expected_sig = '0;
  logic        busy, done, pass;
  logic [31:0] signature;
  logic [15:0] vec_count;
`ifdef EXPR_SIG_PARITY_EN
  logic        par_err;
`endif

  int checks = 0;
  int errors = 0;

  expr_sig_compactor_if #(.Y_WIDTH(90)) bus ();

  expr_sig_compactor dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_vectors  (num_vectors),
    .up           (bus),
    .expected_sig (expected_sig),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
`ifdef EXPR_SIG_PARITY_EN
    .par_err      (par_err),
`endif
    .vec_count    (vec_count)
  );

  always #5 clk = ~clk;

  // Signature of the first n vectors of a run: CRC-style shift over the XOR of 32-bit chunks.
  function automatic logic [31:0] model_sig(input logic [89:0] ys[$], input int n);
    logic [31:0] s;
    logic [95:0] w;
    logic [31:0] f;
    s = SEED;
    for (int k = 0; k < n; k++) begin
      w = {6'b0, ys[k]};
      f = w[31:0] ^ w[63:32] ^ w[95:64];
      s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    end
    return s;
  endfunction

  function automatic logic [89:0] rand_y();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[89:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input logic [31:0] exp_sig);
    start        = 1'b1;
    num_vectors  = 16'(n);
    expected_sig = exp_sig;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [89:0] y);
    bus.in_valid = 1'b1;
    bus.in_y     = y;
`ifdef EXPR_SIG_PARITY_EN
    bus.in_par   = ^y;
`endif
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass); end
    checks++; if (signature !== SEED) begin errors++; $display("FAIL reset_sig got %h exp %h", signature, SEED); end
    checks++; if (vec_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", vec_count); end
  endtask

  task automatic test_single_zero();
    do_start(1, 32'hFB3EE249);
    checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_run_entry got busy=%b ready=%b exp 1 1", busy, bus.in_ready); end
    send(90'h0);
    checks++; if (signature !== 32'hFB3EE249) begin errors++; $display("FAIL zero_sig got %h exp FB3EE249", signature); end
    checks++; if (vec_count !== 16'd1) begin errors++; $display("FAIL zero_count got %0d exp 1", vec_count); end
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL zero_pass got done=%b pass=%b exp 1 1", done, pass); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_ready_drop got %b exp 0", bus.in_ready); end
    do_start(1, 32'h0);
    send(90'h0);
    checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL zero_fail got done=%b pass=%b exp 1 0", done, pass); end
  endtask

  task automatic test_fold_alias();
    logic [89:0] v;
    do_start(1, 32'hFB3EE248);
    send(90'h1);
    checks++; if (signature !== 32'hFB3EE248) begin errors++; $display("FAIL alias_lsb got %h exp FB3EE248", signature); end
    v = 90'h1;
    v = v << 64;
    do_start(1, 32'hFB3EE248);
    send(v);
    checks++; if (signature !== 32'hFB3EE248 || pass !== 1'b1) begin errors++; $display("FAIL alias_hi got %h pass=%b exp FB3EE248 1", signature, pass); end
  endtask

  task automatic test_gap_valid();
    logic [89:0] q[$];
    logic [31:0] exp_sig;
    logic [31:0] gap_sig;
    int idx;
    q = {};
    for (int k = 0; k < 3; k++) q.push_back(rand_y());
    exp_sig = model_sig(q, 3);
    do_start(3, exp_sig);
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      bus.in_valid = (cyc % 2 == 0);
      bus.in_y     = bus.in_valid ? q[idx] : rand_y();
`ifdef EXPR_SIG_PARITY_EN
      bus.in_par   = ^bus.in_y;
`endif
      if (bus.in_valid) idx++;
      tick();
      if (cyc == 1) begin
        checks++; if (vec_count !== 16'd1) begin errors++; $display("FAIL gap_mid_count got %0d exp 1", vec_count); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (vec_count !== 16'd3) begin errors++; $display("FAIL gap_count got %0d exp 3", vec_count); end
    checks++; if (bus.in_ready !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL gap_ready got ready=%b done=%b exp 0 1", bus.in_ready, done); end
    checks++; if (signature !== exp_sig || pass !== 1'b1) begin errors++; $display("FAIL gap_sig got %h pass=%b exp %h 1", signature, pass, exp_sig); end
    gap_sig = signature;
    send(rand_y());
    checks++; if (vec_count !== 16'd3 || signature !== exp_sig) begin errors++; $display("FAIL gap_extra got %0d %h exp 3 %h", vec_count, signature, exp_sig); end
    do_start(3, exp_sig);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_y     = q[k];
`ifdef EXPR_SIG_PARITY_EN
      bus.in_par   = ^q[k];
`endif
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (signature !== gap_sig || signature !== exp_sig) begin errors++; $display("FAIL b2b_sig got %h exp %h", signature, exp_sig); end
    checks++; if (done !== 1'b1 || vec_count !== 16'd3) begin errors++; $display("FAIL b2b_done got done=%b cnt=%0d exp 1 3", done, vec_count); end
  endtask

  task automatic test_num_zero();
    do_start(0, SEED);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL nz_done got done=%b busy=%b exp 1 0", done, busy); end
    checks++; if (signature !== SEED || vec_count !== 16'd0) begin errors++; $display("FAIL nz_state got %h %0d exp %h 0", signature, vec_count, SEED); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL nz_pass got %b exp 1", pass); end
    do_start(0, 32'h12345678);
    checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL nz_fail got pass=%b done=%b exp 0 1", pass, done); end
  endtask

  task automatic test_abort();
    logic [89:0] q[$];
    logic [31:0] part;
    q = {};
    for (int k = 0; k < 5; k++) q.push_back(rand_y());
    part = model_sig(q, 2);
    do_start(5, model_sig(q, 5));
    send(q[0]);
    send(q[1]);
    start       = 1'b1;
    num_vectors = 16'd9;
    tick();
    start = 1'b0;
    checks++; if (vec_count !== 16'd2 || signature !== part || busy !== 1'b1) begin errors++; $display("FAIL run_start_ignored got %0d %h busy=%b exp 2 %h 1", vec_count, signature, busy, part); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b done=%b ready=%b exp 0 0 0", busy, done, bus.in_ready); end
    checks++; if (signature !== SEED || vec_count !== 16'd0) begin errors++; $display("FAIL abort_regs got %h %0d exp %h 0", signature, vec_count, SEED); end
    do_start(5, model_sig(q, 5));
    for (int k = 0; k < 5; k++) send(q[k]);
    checks++; if (signature !== model_sig(q, 5) || pass !== 1'b1) begin errors++; $display("FAIL abort_rerun got %h pass=%b exp %h 1", signature, pass, model_sig(q, 5)); end
  endtask

  task automatic test_random();
    logic [89:0] q[$];
    logic [31:0] exp_sig;
    logic        want_pass;
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(12, 1);
      q = {};
      for (int k = 0; k < n; k++) q.push_back(rand_y());
      want_pass = ($urandom_range(1, 0) == 1);
      exp_sig   = want_pass ? model_sig(q, n) : (model_sig(q, n) ^ (32'h1 << $urandom_range(31, 0)));
      do_start(n, exp_sig);
      for (int k = 0; k < n; k++) begin
        for (int g = $urandom_range(2, 0); g > 0; g--) begin
          bus.in_valid = 1'b0;
          bus.in_y     = rand_y();
          tick();
        end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready it=%0d k=%0d got %b exp 1", it, k, bus.in_ready); end
        send(q[k]);
        checks++; if (vec_count !== 16'(k + 1) || signature !== model_sig(q, k + 1)) begin errors++; $display("FAIL rnd_step it=%0d k=%0d got %0d %h exp %0d %h", it, k, vec_count, signature, k + 1, model_sig(q, k + 1)); end
      end
      checks++; if (done !== 1'b1 || pass !== want_pass) begin errors++; $display("FAIL rnd_result it=%0d got done=%b pass=%b exp 1 %b", it, done, pass, want_pass); end
    end
  endtask

`ifdef EXPR_SIG_PARITY_EN
  task automatic test_parity();
    logic [89:0] q[$];
    q = {};
    q.push_back(rand_y());
    do_start(1, model_sig(q, 1));
    bus.in_valid = 1'b1;
    bus.in_y     = q[0];
    bus.in_par   = ~(^q[0]);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (par_err !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL parity_err got err=%b pass=%b done=%b exp 1 0 1", par_err, pass, done); end
    do_start(1, model_sig(q, 1));
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL parity_clear got %b exp 0", par_err); end
    send(q[0]);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL parity_good got %b exp 1", pass); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_y     = '0;
`ifdef EXPR_SIG_PARITY_EN
    bus.in_par   = 1'b0;
`endif
    test_reset();
    test_single_zero();
    test_fold_alias();
    test_gap_valid();
    test_num_zero();
    test_abort();
    test_random();
`ifdef EXPR_SIG_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without completing sequence");
    $fatal(1);
  end

endmodule
